// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the int_ctrl interrupt controller.
// Holds the FSM state encoding, vector width and default vector base.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int VEC_W = 20;
    localparam logic [VEC_W-1:0] VEC_BASE_DEF = 20'h00100;

    // A single source still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: sel is the lowest set bit of req,
// have flags that at least one bit is set.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int IDX_W = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] sel,
    output logic             have
);

    // Scanning from the top down lets the lowest set index overwrite the rest.
    always_comb begin
        sel  = '0;
        have = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel  = IDX_W'(i);
                have = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises and edge-detects src, latches pending bits,
// and presents the highest-priority enabled source to the CPU as a held request.
// Optional build macro INT_CTRL_LEVEL_EN adds per-source level-sensitive mode.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no request; captures the selected source when one is ready
//   REQ   | int_in held with a fixed int_num until int_ack
//   GAP   | one cycle of int_in=0 so the CPU sees a clean deassertion
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               N_SRC    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_BASE_DEF,
    parameter int               IDX_W    = idx_width(N_SRC)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_SRC-1:0] src,
    input  logic             en_we,
    input  logic [N_SRC-1:0] en_wdata,
    output logic [N_SRC-1:0] en_q,
    output logic [N_SRC-1:0] pend_q,
    output logic             int_in,
    output logic [VEC_W-1:0] int_num,
`ifdef INT_CTRL_LEVEL_EN
    input  logic [N_SRC-1:0] src_level,
`endif
    input  logic             int_ack
);

    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] en_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr_bit;
    logic [N_SRC-1:0] pend_edge;
    logic [N_SRC-1:0] cand;

    state_e           state_q, state_d;
    logic             int_in_q, int_in_d;
    logic [VEC_W-1:0] int_num_q, int_num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ack_hit;

    logic [IDX_W-1:0] sel;
    logic             have;

    assign cand = pend_q & en_q;

    int_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req  (cand),
        .sel  (sel),
        .have (have)
    );

    always_comb begin
        state_d   = state_q;
        int_in_d  = int_in_q;
        int_num_d = int_num_q;
        idx_d     = idx_q;
        ack_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (have) begin
                    idx_d     = sel;
                    int_num_d = VEC_BASE + VEC_W'(sel);
                    int_in_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            // No preemption and no withdrawal on enable change: only ack ends REQ.
            REQ: begin
                if (int_ack) begin
                    int_in_d = 1'b0;
                    ack_hit  = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                int_in_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_comb begin
        sync1_d = src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        for (int i = 0; i < N_SRC; i++) begin
            clr_bit[i] = ack_hit && (idx_q == IDX_W'(i));
        end
        // A new edge in the ack cycle must survive the clear.
        pend_edge = rise | (pend_q & ~clr_bit);
`ifdef INT_CTRL_LEVEL_EN
        pend_d = (src_level & sync2_q) | (~src_level & pend_edge);
`else
        pend_d = pend_edge;
`endif
        en_d = en_we ? en_wdata : en_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            state_q   <= IDLE;
            int_in_q  <= 1'b0;
            int_num_q <= '0;
            idx_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            state_q   <= state_d;
            int_in_q  <= int_in_d;
            int_num_q <= int_num_d;
            idx_q     <= idx_d;
        end
    end

    assign int_in  = int_in_q;
    assign int_num = int_num_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed latency/priority/collision cases
// followed by randomized enable/pulse rounds against a set-based model.
module tb_int_ctrl;

    localparam int          N  = 8;
    localparam logic [19:0] VB = 20'h00100;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [N-1:0] src;
    logic         en_we;
    logic [N-1:0] en_wdata;
    logic [N-1:0] en_q;
    logic [N-1:0] pend_q;
    logic         int_in;
    logic [19:0]  int_num;
    logic         int_ack;
`ifdef INT_CTRL_LEVEL_EN
    logic [N-1:0] src_level;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] exp_q[$];
    logic [N-1:0] pend_m;
    logic [N-1:0] en_m;

    always #5 clk = ~clk;

    int_ctrl #(.N_SRC(N), .VEC_BASE(VB)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .src      (src),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .en_q     (en_q),
        .pend_q   (pend_q),
        .int_in   (int_in),
        .int_num  (int_num),
`ifdef INT_CTRL_LEVEL_EN
        .src_level(src_level),
`endif
        .int_ack  (int_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: every set bit of mask is served once, lowest index first.
    task automatic serve(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[i]) exp_q.push_back(VB + 20'(i));
    endtask

    task automatic write_en(input logic [N-1:0] v);
        en_we = 1'b1;
        en_wdata = v;
        tick();
        en_we = 1'b0;
    endtask

    task automatic wait_int(input int max);
        int n = 0;
        while (!int_in && n < max) begin
            tick();
            n++;
        end
        check("wait_int_timeout", {31'd0, int_in}, 32'd1);
    endtask

    task automatic ack_once();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("int_in_after_ack", {31'd0, int_in}, 32'd0);
    endtask

    task automatic drain();
        int budget = 400;
        int quiet = 0;
        while (quiet < 8 && budget > 0) begin
            tick();
            budget--;
            if (int_in) begin
                quiet = 0;
                repeat ($urandom_range(0, 3)) tick();
                ack_once();
            end else begin
                quiet++;
            end
        end
        check("drain_timeout", {31'd0, budget == 0}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        repeat (2) tick();
        clr_n = 1'b1;
        tick();
    endtask

    // Monitor: pops the expected vector on every int_in rise and checks hold.
    logic        mon_prev = 1'b0;
    logic [19:0] mon_held = '0;
    always @(negedge clk) begin
        if (!clr_n) begin
            mon_prev = 1'b0;
        end else begin
            if (int_in && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_request", {12'd0, int_num}, 32'hFFFFFFFF);
                end else begin
                    check("int_num", {12'd0, int_num}, {12'd0, exp_q.pop_front()});
                end
                mon_held = int_num;
            end else if (int_in && mon_prev) begin
                if (int_num !== mon_held)
                    check("int_num_hold", {12'd0, int_num}, {12'd0, mon_held});
            end
            mon_prev = int_in;
        end
    end

    initial begin
        logic [N-1:0] pulse;
        clr_n = 1'b0;
        src = '0;
        en_we = 1'b0;
        en_wdata = '0;
        int_ack = 1'b0;
`ifdef INT_CTRL_LEVEL_EN
        src_level = '0;
`endif
        repeat (2) tick();
        check("rst_int_in", {31'd0, int_in}, 32'd0);
        check("rst_int_num", {12'd0, int_num}, 32'd0);
        check("rst_en_q", {24'd0, en_q}, 32'd0);
        check("rst_pend_q", {24'd0, pend_q}, 32'd0);
        clr_n = 1'b1;
        tick();

        // Single source latency
        write_en(8'h04);
        exp_q.push_back(20'h00102);
        src[2] = 1'b1;
        tick();
        check("pend_t0", {24'd0, pend_q}, 32'h00);
        tick();
        tick();
        src[2] = 1'b0;
        check("pend_t2", {24'd0, pend_q}, 32'h04);
        check("int_in_t2", {31'd0, int_in}, 32'd0);
        tick();
        check("int_in_t3", {31'd0, int_in}, 32'd1);
        check("int_num_t3", {12'd0, int_num}, 32'h00102);
        ack_once();
        check("pend_after_ack", {24'd0, pend_q}, 32'h00);
        repeat (5) tick();
        check("no_retrigger", {31'd0, int_in}, 32'd0);

        // Priority, no preemption
        write_en(8'hFF);
        exp_q.push_back(20'h00105);
        exp_q.push_back(20'h00101);
        src[5] = 1'b1;
        repeat (2) tick();
        src[5] = 1'b0;
        wait_int(10);
        src[1] = 1'b1;
        repeat (2) tick();
        src[1] = 1'b0;
        repeat (4) tick();
        check("nopreempt_int_in", {31'd0, int_in}, 32'd1);
        check("nopreempt_num", {12'd0, int_num}, 32'h00105);
        check("nopreempt_pend", {24'd0, pend_q}, 32'h22);
        ack_once();
        tick();
        check("gap_int_in", {31'd0, int_in}, 32'd0);
        tick();
        check("after_gap_int_in", {31'd0, int_in}, 32'd1);
        check("after_gap_num", {12'd0, int_num}, 32'h00101);
        ack_once();

        // Disabled source is latched and served once enabled
        write_en(8'h00);
        src[3] = 1'b1;
        repeat (2) tick();
        src[3] = 1'b0;
        repeat (4) tick();
        check("dis_pend", {24'd0, pend_q}, 32'h08);
        check("dis_int_in", {31'd0, int_in}, 32'd0);
        exp_q.push_back(20'h00103);
        write_en(8'h08);
        check("en_write_int_in", {31'd0, int_in}, 32'd0);
        check("en_q_written", {24'd0, en_q}, 32'h08);
        tick();
        check("en_int_in", {31'd0, int_in}, 32'd1);
        check("en_int_num", {12'd0, int_num}, 32'h00103);
        ack_once();

        // Set/clear collision on source 0
        write_en(8'h01);
        exp_q.push_back(20'h00100);
        exp_q.push_back(20'h00100);
        src[0] = 1'b1;
        repeat (2) tick();
        src[0] = 1'b0;
        wait_int(10);
        repeat (4) tick();
        src[0] = 1'b1;
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        src[0] = 1'b0;
        check("coll_int_in", {31'd0, int_in}, 32'd0);
        check("coll_pend", {24'd0, pend_q}, 32'h01);
        wait_int(5);
        check("coll_num", {12'd0, int_num}, 32'h00100);
        ack_once();
        check("coll_pend_clear", {24'd0, pend_q}, 32'h00);

        // Reset mid-request
        write_en(8'hFF);
        exp_q.push_back(20'h00106);
        src[6] = 1'b1;
        repeat (2) tick();
        src[6] = 1'b0;
        wait_int(10);
        #2 clr_n = 1'b0;
        #1 check("async_drop", {31'd0, int_in}, 32'd0);
        tick();
        clr_n = 1'b1;
        tick();
        check("post_rst_en", {24'd0, en_q}, 32'h00);
        check("post_rst_pend", {24'd0, pend_q}, 32'h00);
        check("post_rst_num", {12'd0, int_num}, 32'h00000);

`ifdef INT_CTRL_LEVEL_EN
        src_level = 8'h10;
        write_en(8'h10);
        exp_q.push_back(20'h00104);
        exp_q.push_back(20'h00104);
        src[4] = 1'b1;
        wait_int(10);
        ack_once();
        wait_int(5);
        check("lvl_num", {12'd0, int_num}, 32'h00104);
        src[4] = 1'b0;
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("lvl_pend_drop", {24'd0, pend_q}, 32'h00);
        repeat (8) tick();
        check("lvl_no_more", {31'd0, int_in}, 32'd0);
        src_level = '0;
`endif

        // Randomized rounds against the set-based model
        do_reset();
        pend_m = '0;
        en_m = '0;
        for (int r = 0; r < 24; r++) begin
            en_m = 8'($urandom);
            serve(pend_m & en_m);
            pend_m &= ~en_m;
            write_en(en_m);
            drain();
            check("rnd_pend_after_en", {24'd0, pend_q}, {24'd0, pend_m});
            pulse = 8'($urandom);
            pend_m |= pulse;
            serve(pend_m & en_m);
            pend_m &= ~en_m;
            src = pulse;
            repeat ($urandom_range(1, 4)) tick();
            src = '0;
            drain();
            check("rnd_pend", {24'd0, pend_q}, {24'd0, pend_m});
            check("rnd_en", {24'd0, en_q}, {24'd0, en_m});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller on the sending end of the CPU interrupt interface (int_in / int_ack / int_num).
- Collects N_SRC external interrupt lines, synchronises and edge-detects them, latches pending bits, and gates them with an enable register.
- Presents the highest-priority pending, enabled source to the CPU as a held request with a 20-bit vector number.
- Withdraws the request after int_ack.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32); index 0 has the highest priority.
- VEC_BASE, 20'h00100, vector number reported for source 0.
- IDX_W, $clog2(N_SRC) (min 1), width of the source index.

Ports:
- clk  input  1  system clock
- clr_n  input  1  asynchronous active-low reset
- src  input  N_SRC  raw interrupt lines, asynchronous to clk, active high
- en_we  input  1  write strobe for the enable register
- en_wdata  input  N_SRC  new enable value
- en_q  output  N_SRC  current enable register
- pend_q  output  N_SRC  current pending register (debug/status)
- int_in  output  1  interrupt request to CPU
- int_num  output  20  vector number, valid while int_in=1
- int_ack  input  1  CPU acknowledge, sampled on the clk rising edge

Behaviour:
- Clock and reset: one clock domain (clk); clr_n is asynchronous, active low.
- Reset values: int_in=0, int_num=0, en_q=0 (all sources disabled), pend_q=0, synchroniser and edge flops 0, FSM state=IDLE.
- Synchroniser: 2-flop chain per src bit, then a prev flop. rise[i] = sync2[i] & ~prev[i].
- Pending: pend[i] <= rise[i] | (pend[i] & ~clr_bit[i]).
  - clr_bit is set only for the acknowledged index in the ack cycle.
  - Set wins over clear when both happen in the same cycle.
- Pending ignores the enable register: a disabled source still latches pend and is served once enabled.
- Selection: sel = lowest i with pend[i] & en_q[i]. Combinational priority encoder; have = OR of those terms.
- FSM:
  - IDLE: if have, capture idx<=sel, int_num<=VEC_BASE+sel, int_in<=1 -> REQ.
  - REQ: int_in and int_num are held constant. On int_ack=1: int_in<=0, clear pend[idx] -> GAP. A later higher-priority source does not preempt an outstanding request. Clearing en_q[idx] does not withdraw the request either.
  - GAP: one cycle with int_in=0, so the CPU sees a clean deassertion -> IDLE.
  - int_ack while in IDLE or GAP is ignored.
- Latency:
  - t0 is the first edge at which src[i]=1 is sampled.
  - pend[i]=1 after t2; int_in=1 after t3, with en_q[i]=1 and the FSM in IDLE.
  - Ack at edge ta gives int_in=0 after ta. Earliest next int_in is after ta+2.
- Width rule: int_num = VEC_BASE + zero-extended idx, 20 bits, wrap modulo 2^20.
- en_we: en_q <= en_wdata on the same edge. The new value affects selection from the next cycle.
- Reset mid-request: int_in drops immediately (asynchronously); all pending state is lost.
- A src held high yields one pending event; it must go low and high again to re-trigger.

Optional Feature:
- Macro: INT_CTRL_LEVEL_EN.
- Defined:
  - Adds input port src_level [N_SRC-1:0].
  - For bits with src_level[i]=1: pend[i] = sync2[i] (level-sensitive); ack does not clear it. The request re-asserts after GAP while the line stays high.
  - Bits with src_level[i]=0 behave as edge sources.
- Undefined: the port is absent and all sources are edge-triggered as above.

Decomposition:
- Shared package int_ctrl_pkg holds:
  - FSM state typedef {IDLE, REQ, GAP} (2 bits)
  - VEC_W=20 constant
  - default VEC_BASE
- One sub-module, int_prio_enc: parameterised N_SRC lowest-index-first encoder with outputs sel[IDX_W-1:0] and have.

Test Plan:
- Reset: clr_n=0 mid-REQ -> int_in=0 at once; after release en_q=0, pend_q=0, int_num=0.
- Single source: en_q=8'h04, pulse src[2] high for 3 cycles -> pend_q=8'h04 after t2; int_in=1 and int_num=20'h00102 after t3; ack one cycle -> int_in=0 next edge, pend_q=0.
- Priority and no preemption:
  - src[5] raised, then src[1] raised while the request for 5 is held -> int_num stays 20'h00105 until ack.
  - After GAP -> int_num=20'h00101.
- Disabled source: en_q=0, pulse src[3] -> pend_q=8'h08, int_in stays 0; write en_wdata=8'h08 -> int_in=1 with int_num=20'h00103 after 2 cycles.
- Set/clear collision: src[0] second rising edge detected in the same cycle as ack of source 0 -> pend_q[0] stays 1; a second request with int_num=20'h00100 follows after GAP.
- INT_CTRL_LEVEL_EN: src_level[4]=1, src[4] held high, ack twice -> two requests with int_num=20'h00104; drop src[4] -> pend_q[4]=0 three edges later, no further int_in.
